as_fetchstage: RTL
==================

Name: as_fetchstage

Overview:
- Instruction-fetch stage of the RV64I pipeline, directly upstream of the decode stage.
- Owns the PC register and the request/response handshake to instruction memory (one outstanding request, variable latency).
- Owns the IF/ID pipeline register that presents instruction, PC and PC+4 to decode.
- Honours hazard-unit stall/flush and EX-stage redirects; a redirect discards any in-flight memory response.

Parameters:
- RESET_VECTOR, 64'h0000_0000_0000_0000, PC of the first fetch after reset.
- ADDR_WIDTH, 64, PC/address width.
- INSTR_WIDTH, 32, instruction width.
- NOP_INSTR, 32'h0000_0013, bubble inserted on flush/reset (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  ADDR_WIDTH  fetch address, bits[1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle
- imem_valid_i  in  1  response data valid this cycle
- imem_rdata_i  in  INSTR_WIDTH  response instruction
- stall_i  in  1  hazard unit: hold IF/ID and PC
- flush_i  in  1  hazard unit: load bubble into IF/ID
- redirect_i  in  1  EX: taken branch/jump
- redirect_pc_i  in  ADDR_WIDTH  redirect target; bits[1:0] forced to 0
- instr_o  out  INSTR_WIDTH  IF/ID instruction to decode
- pc_o  out  ADDR_WIDTH  IF/ID PC of instr_o
- pc_plus4_o  out  ADDR_WIDTH  IF/ID pc_o+4
- valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, any state):
  - pc_q=RESET_VECTOR, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=0, valid_o=0, state=REQ.
  - imem_req_o=0 while rst_i=1; the first request is asserted in the first cycle after deassertion.
- pc_q is the address of the outstanding or next request. imem_addr_o=pc_q except for the back-to-back case below. All adds wrap modulo 2^ADDR_WIDTH.
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ:
  - imem_req_o=1.
  - gnt=1 -> WAIT; gnt=0 -> stay in REQ, address held stable.
- WAIT (waiting for response; imem_req_o=0 unless back-to-back):
  - valid=1, stall=0: load IF/ID with {imem_rdata_i, pc_q, pc_q+4, valid=1} and set pc_q<=pc_q+4.
    - Same cycle, assert imem_req_o with imem_addr_o=pc_q+4 (back-to-back). gnt=1 -> stay WAIT; gnt=0 -> REQ.
    - Zero-wait memory therefore sustains 1 instruction/cycle.
  - valid=1, stall=1: capture response into hold buffer (instr, pc_q) -> HOLD. pc_q still advances by 4.
  - valid=0: stay.
- HOLD:
  - imem_req_o=0.
  - stall=0: load IF/ID from hold buffer with valid=1 -> REQ.
- DROP:
  - Discards exactly one pending response; imem_req_o=0.
  - On valid=1 -> REQ; IF/ID untouched.
- stall_i=1 (no flush/redirect): IF/ID and pc_q hold values; no new request is issued from WAIT/HOLD. An already-asserted REQ may still complete its grant.
- flush_i=1: IF/ID <= {NOP_INSTR, pc_o, pc_plus4_o, valid=0}. Flush has priority over stall for IF/ID. If in HOLD, the buffered instruction is still delivered once stall is low (flush kills only the IF/ID content).
- redirect_i=1 has highest priority, above stall and flush:
  - IF/ID bubble (as flush); pc_q<=redirect_pc_i & ~3.
  - REQ with gnt=0: -> REQ. New address is presented next cycle.
  - REQ with gnt=1: -> DROP.
  - WAIT with valid=0: -> DROP.
  - WAIT with valid=1: response discarded; no back-to-back request -> REQ.
  - HOLD: buffer discarded -> REQ.
  - DROP: stay in DROP if valid=0, else -> REQ.
- Redirect during stall: redirect still applied; fetch resumes only via REQ.
- Invariant: at most one outstanding granted request; a discarded response never reaches IF/ID.

Test Plan:
- Reset with RESET_VECTOR=0x1000 and zero-wait memory (gnt=1, valid one cycle later) -> imem_addr_o=0x1000,0x1004,0x1008 on consecutive cycles; pc_o follows one cycle behind valid; valid_o=1 from the first response; pc_plus4_o=pc_o+4.
- gnt low for 3 cycles at 0x1004 -> imem_addr_o stable at 0x1004 throughout; no IF/ID update; then normal flow.
- stall_i high 2 cycles while response 0x00500093 arrives -> IF/ID holds its prior value; after stall drops, instr_o=0x00500093 with correct pc; no duplicate or lost instruction.
- redirect_i with target 0x2002 while in WAIT, response arrives 2 cycles later -> response discarded; next imem_addr_o=0x2000; valid_o=0 for the bubble cycle.
- redirect and valid in the same cycle, with stall and flush also high -> bubble in IF/ID; next request to the target; no stale instruction delivered.
- rst_i asserted mid-WAIT -> outputs reset immediately (async); after release first request goes to RESET_VECTOR; late imem_valid_i during reset is ignored.

Source files
------------

// File: rtl/as_fetchstage.sv
// RV64I instruction-fetch stage: PC register, single-outstanding imem handshake
// and the IF/ID pipeline register feeding decode.
module as_fetchstage #(
    parameter int unsigned            ADDR_WIDTH   = 64,
    parameter int unsigned            INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
    output logic                   valid_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_q;
    logic [ADDR_WIDTH-1:0]    pc_inc;
    logic [ADDR_WIDTH-1:0]    hold_pc_q;
    logic [INSTR_WIDTH-1:0]   hold_instr_q;
    logic                     consume;

    logic                     req_c;
    logic [ADDR_WIDTH-1:0]    addr_c;
    logic                     pc_adv_c;
    logic                     load_resp_c;
    logic                     load_hold_c;
    logic                     capture_c;

    assign pc_inc = pc_q + PC_STEP;
    // A flush without redirect only bubbles IF/ID; a response arriving under it is
    // parked in the hold buffer so no instruction is lost.
    assign consume = ~stall_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (redirect_i) begin
                    state_d = imem_gnt_i ? ST_DROP : ST_REQ;
                end else if (imem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_valid_i ? ST_REQ : ST_DROP;
                end else if (imem_valid_i) begin
                    if (consume) begin
                        state_d = imem_gnt_i ? ST_WAIT : ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_i || consume) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Request and datapath strobes; back-to-back fetch issues pc_q+4 while the response lands.
    always_comb begin
        req_c       = 1'b0;
        addr_c      = pc_q;
        pc_adv_c    = 1'b0;
        load_resp_c = 1'b0;
        load_hold_c = 1'b0;
        capture_c   = 1'b0;
        case (state_q)
            ST_REQ: begin
                req_c = 1'b1;
            end
            ST_WAIT: begin
                if (!redirect_i && imem_valid_i) begin
                    pc_adv_c = 1'b1;
                    if (consume) begin
                        load_resp_c = 1'b1;
                        req_c       = 1'b1;
                        addr_c      = pc_inc;
                    end else begin
                        capture_c = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                load_hold_c = ~redirect_i & consume;
            end
            default: ;
        endcase
    end

    assign imem_req_o  = req_c & ~rst_i;
    assign imem_addr_o = addr_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_VECTOR;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
            instr_o      <= NOP_INSTR;
            pc_o         <= '0;
            pc_plus4_o   <= '0;
            valid_o      <= 1'b0;
        end else begin
            if (redirect_i) begin
                pc_q <= redirect_pc_i & ALIGN_MASK;
            end else if (pc_adv_c) begin
                pc_q <= pc_inc;
            end

            if (capture_c) begin
                hold_instr_q <= imem_rdata_i;
                hold_pc_q    <= pc_q;
            end

            // Bubble keeps the old PC pair so decode still sees a coherent (invalid) slot.
            if (redirect_i || flush_i) begin
                instr_o <= NOP_INSTR;
                valid_o <= 1'b0;
            end else if (load_resp_c) begin
                instr_o    <= imem_rdata_i;
                pc_o       <= pc_q;
                pc_plus4_o <= pc_inc;
                valid_o    <= 1'b1;
            end else if (load_hold_c) begin
                instr_o    <= hold_instr_q;
                pc_o       <= hold_pc_q;
                pc_plus4_o <= hold_pc_q + PC_STEP;
                valid_o    <= 1'b1;
            end
        end
    end

endmodule
